// File: rtl/nor_bus_sched.sv
// nor_bus_sched: two-requester scheduler for an asynchronous parallel NOR flash.
// Arbitrates between m0 and m1, then runs one access with fixed setup, strobe
// and hold timing. Writes then wait on RY/BY# with a timeout.
//
// Ports
//   clk_i, reset_ni             clock (rising edge), async active-low reset
//   mN_stb_i/we_i/addr_i/data_i requester strobe, write flag, word address, write data
//   mN_ack_o/data_o             one-cycle completion pulse, captured read data
//   nor_addr_o/data_o/data_oe   NOR address, write data, DQ drive enable
//   nor_data_i                  NOR DQ input
//   nor_ce_o/oe_o/we_o          active-low NOR strobes
//   nor_ry_i                    NOR RY/BY#, asynchronous to clk_i
//   busy_o, timeout_o           access in progress, RY/BY# wait expired (ACK cycle)
module nor_bus_sched #(
  parameter int TSU  = 1,
  parameter int TRD  = 5,
  parameter int TWP  = 3,
  parameter int THLD = 1,
  parameter int TO   = 4096
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        m0_stb_i,
  input  logic        m1_stb_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [25:0] m0_addr_i,
  input  logic [25:0] m1_addr_i,
  input  logic [15:0] m0_data_i,
  input  logic [15:0] m1_data_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic [15:0] m0_data_o,
  output logic [15:0] m1_data_o,
  output logic [25:0] nor_addr_o,
  output logic [15:0] nor_data_o,
  output logic        nor_data_oe,
  input  logic [15:0] nor_data_i,
  output logic        nor_ce_o,
  output logic        nor_oe_o,
  output logic        nor_we_o,
  input  logic        nor_ry_i,
  output logic        busy_o,
  output logic        timeout_o
);

  // RYWAIT always lasts at least two cycles, so the timeout is never shorter.
  localparam int RW   = (TO < 2) ? 2 : TO;
  localparam int MX1  = (TSU > TRD) ? TSU : TRD;
  localparam int MX2  = (MX1 > TWP) ? MX1 : TWP;
  localparam int MX3  = (MX2 > THLD) ? MX2 : THLD;
  localparam int CMAX = (MX3 > RW) ? MX3 : RW;
  localparam int CW   = $clog2(CMAX + 1);

  // The shared counter is loaded with N-1 on entry and the state exits at zero.
  localparam logic [CW-1:0] TSU_L  = CW'(TSU - 1);
  localparam logic [CW-1:0] TRD_L  = CW'(TRD - 1);
  localparam logic [CW-1:0] TWP_L  = CW'(TWP - 1);
  localparam logic [CW-1:0] THLD_L = CW'(THLD - 1);
  localparam logic [CW-1:0] RW_L   = CW'(RW - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, HOLD, RYWAIT, ACK
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_q;      // 1 = m1 owns the current access
  logic          last_q;     // last granted requester, 1 = m1
  logic          we_q;
  logic          ry_meta_q, ry_sync_q;
  logic [25:0]   nor_addr_q;
  logic [15:0]   nor_data_q;
  logic          doe_q, ce_q, oe_q, wen_q;
  logic          ack0_q, ack1_q;
  logic [15:0]   rd0_q, rd1_q;
  logic          busy_q, to_q;

  logic          gnt_d;
  logic          sel_we_d;
  logic [25:0]   sel_addr_d;
  logic [15:0]   sel_data_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Arbitration: a sole strobe wins, a tie goes to whoever did not win last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    gnt_d = 1'b0;
    if (m0_stb_i && m1_stb_i) gnt_d = ~last_q;
    else if (m1_stb_i)        gnt_d = 1'b1;
    sel_we_d   = gnt_d ? m1_we_i   : m0_we_i;
    sel_addr_d = gnt_d ? m1_addr_i : m0_addr_i;
    sel_data_d = gnt_d ? m1_data_i : m0_data_i;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      ry_meta_q  <= 1'b1;
      ry_sync_q  <= 1'b1;
      nor_addr_q <= '0;
      nor_data_q <= '0;
      doe_q      <= 1'b0;
      ce_q       <= 1'b1;
      oe_q       <= 1'b1;
      wen_q      <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      ry_meta_q <= nor_ry_i;
      ry_sync_q <= ry_meta_q;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (m0_stb_i || m1_stb_i) begin
            gnt_q      <= gnt_d;
            last_q     <= gnt_d;
            we_q       <= sel_we_d;
            nor_addr_q <= sel_addr_d;
            nor_data_q <= sel_data_d;
            doe_q      <= sel_we_d;
            ce_q       <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= TSU_L;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_zero) begin
            oe_q    <= we_q;
            wen_q   <= ~we_q;
            cnt_q   <= we_q ? TWP_L : TRD_L;
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ACCESS: begin
          if (cnt_zero) begin
            if (!we_q) begin
              if (gnt_q) rd1_q <= nor_data_i;
              else       rd0_q <= nor_data_i;
            end
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            cnt_q   <= THLD_L;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        HOLD: begin
          if (cnt_zero) begin
            doe_q <= 1'b0;
            ce_q  <= 1'b1;
            if (we_q) begin
              cnt_q   <= RW_L;
              state_q <= RYWAIT;
            end else begin
              ack0_q  <= ~gnt_q;
              ack1_q  <= gnt_q;
              state_q <= ACK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        RYWAIT: begin
          // The first RYWAIT cycle ignores RY: the device needs time to assert busy.
          if ((cnt_q != RW_L) && ry_sync_q) begin
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= ACK;
          end else if (cnt_zero) begin
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            to_q    <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ACK: begin
          to_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack_o    = ack0_q;
  assign m1_ack_o    = ack1_q;
  assign m0_data_o   = rd0_q;
  assign m1_data_o   = rd1_q;
  assign nor_addr_o  = nor_addr_q;
  assign nor_data_o  = nor_data_q;
  assign nor_data_oe = doe_q;
  assign nor_ce_o    = ce_q;
  assign nor_oe_o    = oe_q;
  assign nor_we_o    = wen_q;
  assign busy_o      = busy_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_nor_bus_sched.sv
// Testbench for nor_bus_sched: NOR device model on the bus, scoreboard of
// expected completions popped on every ack, per-scenario bus-timing checks.
module tb_nor_bus_sched;

  localparam int TSU   = 1;
  localparam int TRD   = 5;
  localparam int TWP   = 3;
  localparam int THLD  = 1;
  localparam int TO_TB = 16;

  logic        clk, reset_ni;
  logic        m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
  logic [25:0] m0_addr_i, m1_addr_i;
  logic [15:0] m0_data_i, m1_data_i;
  logic        m0_ack_o, m1_ack_o;
  logic [15:0] m0_data_o, m1_data_o;
  logic [25:0] nor_addr_o;
  logic [15:0] nor_data_o, nor_data_i;
  logic        nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o, nor_ry_i;
  logic        busy_o, timeout_o;

  nor_bus_sched #(.TSU(TSU), .TRD(TRD), .TWP(TWP), .THLD(THLD), .TO(TO_TB)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_data_i(m0_data_i), .m1_data_i(m1_data_i),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_data_o(m0_data_o), .m1_data_o(m1_data_o),
    .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe(nor_data_oe),
    .nor_data_i(nor_data_i),
    .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o),
    .nor_ry_i(nor_ry_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- NOR device model ----------------
  logic [15:0] dev_mem [logic [25:0]];
  logic [15:0] ref_mem [logic [25:0]];

  function automatic logic [15:0] dev_rd(input logic [25:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [25:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a[15:0] ^ 16'h5A5A);
  endfunction

  // DQ is only valid while the device is selected and output-enabled.
  assign nor_data_i = (!nor_ce_o && !nor_oe_o) ? dev_rd(nor_addr_o) : 16'hDEAD;

  always @(posedge nor_we_o)
    if (nor_ce_o === 1'b0 && nor_data_oe === 1'b1) dev_mem[nor_addr_o] = nor_data_o;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        gnt;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        to;
    int          ack_cyc;
  } sb_t;

  sb_t         sb[$];
  logic        model_last;
  logic [15:0] exp_d0, exp_d1;
  logic [15:0] last_wdata;

  always @(negedge clk) begin
    sb_t e;
    if (reset_ni && (m0_ack_o || m1_ack_o)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b at cycle %0d, required no ack", m0_ack_o, m1_ack_o, cyc);
      end else begin
        e = sb.pop_front();
        vectors++;
        if ({m1_ack_o, m0_ack_o} !== (e.gnt ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL ack_owner: got {m1,m0}=%b, required %b", {m1_ack_o, m0_ack_o}, (e.gnt ? 2'b10 : 2'b01));
        end
        vectors++;
        if (cyc !== e.ack_cyc) begin
          miscompares++;
          $display("FAIL ack_latency: ack at cycle %0d, required %0d", cyc, e.ack_cyc);
        end
        vectors++;
        if (timeout_o !== e.to) begin
          miscompares++;
          $display("FAIL ack_timeout: timeout_o=%b, required %b", timeout_o, e.to);
        end
        vectors++;
        if (m0_data_o !== e.d0) begin
          miscompares++;
          $display("FAIL m0_data: got %h, required %h", m0_data_o, e.d0);
        end
        vectors++;
        if (m1_data_o !== e.d1) begin
          miscompares++;
          $display("FAIL m1_data: got %h, required %h", m1_data_o, e.d1);
        end
      end
    end else if (reset_ni && timeout_o) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_timeout: timeout_o=1 without ack at cycle %0d, required 0", cyc);
    end
  end

  // Called at a negedge; the following posedge is the sampling edge.
  task automatic start(input logic s0, input logic s1, input logic w0, input logic w1,
                       input logic [25:0] a0, input logic [25:0] a1,
                       input logic [15:0] dd0, input logic [15:0] dd1,
                       input bit push, input bit ry_low);
    logic g, w;
    logic [25:0] a;
    logic [15:0] d;
    int lat;
    sb_t e;
    m0_stb_i = s0;  m1_stb_i = s1;
    m0_we_i = w0;   m1_we_i = w1;
    m0_addr_i = a0; m1_addr_i = a1;
    m0_data_i = dd0; m1_data_i = dd1;
    g = (s0 && s1) ? ~model_last : s1;
    model_last = g;
    w = g ? w1 : w0;
    a = g ? a1 : a0;
    d = g ? dd1 : dd0;
    last_wdata = d;
    if (w) begin
      lat = TSU + TWP + THLD + 1 + (ry_low ? TO_TB : 2);
      if (push) ref_mem[a] = d;
    end else begin
      lat = TSU + TRD + THLD + 1;
      if (push) begin
        if (g) exp_d1 = ref_rd(a);
        else   exp_d0 = ref_rd(a);
      end
    end
    @(posedge clk); #1;
    e.gnt = g; e.d0 = exp_d0; e.d1 = exp_d1; e.to = w && ry_low;
    e.ack_cyc = cyc + lat - 1;
    if (push) sb.push_back(e);
    // Post-grant input changes must not disturb the access in flight.
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    m0_addr_i = 26'($urandom); m1_addr_i = 26'($urandom);
    m0_data_i = 16'($urandom); m1_data_i = 16'($urandom);
    m0_we_i = ~m0_we_i; m1_we_i = ~m1_we_i;
  endtask

  typedef struct {
    int oe_lo, we_lo, both_lo, doe, doe_ok, ack_idx, idle_idx, ce_lead, ce_tail;
  } meas_t;

  // Samples each cycle after the sampling edge until busy_o is low (bounded).
  task automatic measure(output meas_t m);
    bit seen_ce_lo;
    m = '{default: 0};
    seen_ce_lo = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!nor_oe_o) m.oe_lo++;
      if (!nor_we_o) m.we_lo++;
      if (!nor_oe_o && !nor_we_o) m.both_lo++;
      if (nor_data_oe) begin
        m.doe++;
        if (!nor_ce_o && nor_data_o === last_wdata) m.doe_ok++;
      end
      if (nor_ce_o) begin
        m.ce_tail++;
        if (!seen_ce_lo) m.ce_lead++;
      end else begin
        m.ce_tail = 0;
        seen_ce_lo = 1'b1;
      end
      if ((m0_ack_o || m1_ack_o) && m.ack_idx == 0) m.ack_idx = i;
      if (!busy_o) begin
        m.idle_idx = i;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    vectors++;
    if ({nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe, m0_ack_o, m1_ack_o, busy_o, timeout_o} !== 8'b1110_0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {ce,oe,we,doe,ack0,ack1,busy,to}=%b, required 11100000",
               {nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe, m0_ack_o, m1_ack_o, busy_o, timeout_o});
    end
    vectors++;
    if (nor_addr_o !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h, required 0", nor_addr_o);
    end
    vectors++;
    if (nor_data_o !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h, required 0", nor_data_o);
    end
    vectors++;
    if ({m0_data_o, m1_data_o} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got m0=%h m1=%h, required 0/0", m0_data_o, m1_data_o);
    end
  endtask

  task automatic test_read;
    meas_t m;
    start(1'b1, 1'b0, 1'b0, 1'b0, 26'h0001234, 26'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    measure(m);
    vectors++;
    if (m.oe_lo !== TRD) begin
      miscompares++;
      $display("FAIL read_oe_width: OE low %0d cycles, required %0d", m.oe_lo, TRD);
    end
    vectors++;
    if ({m.we_lo, m.doe, m.both_lo} !== {32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL read_no_drive: we_lo=%0d doe=%0d both=%0d, required 0/0/0", m.we_lo, m.doe, m.both_lo);
    end
    vectors++;
    if (m.idle_idx !== TSU + TRD + THLD + 2) begin
      miscompares++;
      $display("FAIL read_busy: idle at cycle %0d, required %0d", m.idle_idx, TSU + TRD + THLD + 2);
    end
  endtask

  task automatic test_write;
    meas_t m;
    nor_ry_i = 1'b1;
    start(1'b1, 1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 26'h0, 16'hA5A5, 16'h0, 1'b1, 1'b0);
    measure(m);
    vectors++;
    if (m.we_lo !== TWP || m.oe_lo !== 0 || m.both_lo !== 0) begin
      miscompares++;
      $display("FAIL write_we_width: we_lo=%0d oe_lo=%0d both=%0d, required %0d/0/0", m.we_lo, m.oe_lo, m.both_lo, TWP);
    end
    vectors++;
    if (m.doe !== TSU + TWP + THLD || m.doe_ok !== TSU + TWP + THLD) begin
      miscompares++;
      $display("FAIL write_drive: doe=%0d doe_ok=%0d, required %0d", m.doe, m.doe_ok, TSU + TWP + THLD);
    end
    vectors++;
    if (m.ack_idx !== 8) begin
      miscompares++;
      $display("FAIL write_ack_cycle: ack in cycle %0d, required 8", m.ack_idx);
    end
    // Read it back through the other requester.
    start(1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 26'h3FFFFFF, 16'h0, 16'h0, 1'b1, 1'b0);
    measure(m);
    vectors++;
    if (m.idle_idx !== TSU + TRD + THLD + 2) begin
      miscompares++;
      $display("FAIL readback_busy: idle at cycle %0d, required %0d", m.idle_idx, TSU + TRD + THLD + 2);
    end
  endtask

  task automatic test_tie;
    meas_t m;
    int prev_tail;
    prev_tail = 0;
    for (int i = 0; i < 4; i++) begin
      start(1'b1, 1'b1, 1'b0, 1'b1, 26'h100 + 26'(i), 26'h200 + 26'(i), 16'h0, 16'h1000 + 16'(i), 1'b1, 1'b0);
      measure(m);
      vectors++;
      if (m.both_lo !== 0 || m.idle_idx !== 9) begin
        miscompares++;
        $display("FAIL tie_access_%0d: both_lo=%0d idle=%0d, required 0/9", i, m.both_lo, m.idle_idx);
      end
      if (i > 0) begin
        vectors++;
        if (prev_tail + m.ce_lead < 2) begin
          miscompares++;
          $display("FAIL tie_ce_gap_%0d: CE high %0d cycles, required >=2", i, prev_tail + m.ce_lead);
        end
      end
      prev_tail = m.ce_tail;
    end
  endtask

  task automatic test_timeout;
    meas_t m;
    nor_ry_i = 1'b0;
    repeat (4) @(negedge clk);
    start(1'b0, 1'b1, 1'b0, 1'b1, 26'h0, 26'h0AAAAAA, 16'h0, 16'h1357, 1'b1, 1'b1);
    measure(m);
    vectors++;
    if (m.ack_idx !== TSU + TWP + THLD + TO_TB + 1) begin
      miscompares++;
      $display("FAIL timeout_ack_cycle: ack in cycle %0d, required %0d", m.ack_idx, TSU + TWP + THLD + TO_TB + 1);
    end
    vectors++;
    if (m.idle_idx !== m.ack_idx + 1) begin
      miscompares++;
      $display("FAIL timeout_busy_drop: busy low in cycle %0d, required %0d", m.idle_idx, m.ack_idx + 1);
    end
    nor_ry_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    meas_t m;
    start(1'b1, 1'b0, 1'b1, 1'b0, 26'h0123456, 26'h0, 16'h7E7E, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    vectors++;
    if ({nor_we_o, nor_ce_o, nor_data_oe} !== 3'b001) begin
      miscompares++;
      $display("FAIL abort_in_access: {we,ce,doe}=%b, required 001", {nor_we_o, nor_ce_o, nor_data_oe});
    end
    reset_ni = 1'b0;
    model_last = 1'b1;
    exp_d0 = 16'h0;
    exp_d1 = 16'h0;
    #1;
    vectors++;
    if ({nor_we_o, nor_ce_o, nor_data_oe, busy_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL abort_immediate: {we,ce,doe,busy}=%b, required 1100", {nor_we_o, nor_ce_o, nor_data_oe, busy_o});
    end
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    // A tie right after release must go to m0 and be sampled in the first IDLE cycle.
    start(1'b1, 1'b1, 1'b0, 1'b0, 26'h0001234, 26'h0000042, 16'h0, 16'h0, 1'b1, 1'b0);
    measure(m);
    vectors++;
    if (m.idle_idx !== 9) begin
      miscompares++;
      $display("FAIL post_reset_access: idle at cycle %0d, required 9", m.idle_idx);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset_ni = 1'b0;
    nor_ry_i = 1'b1;
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    m0_we_i = 1'b0;  m1_we_i = 1'b0;
    m0_addr_i = '0;  m1_addr_i = '0;
    m0_data_i = '0;  m1_data_i = '0;
    model_last = 1'b1;
    exp_d0 = 16'h0;
    exp_d1 = 16'h0;
    last_wdata = 16'h0;
    dev_mem[26'h0001234] = 16'hBEEF;
    ref_mem[26'h0001234] = 16'hBEEF;
    repeat (3) @(negedge clk);
    test_reset;
    reset_ni = 1'b1;
    @(negedge clk);
    test_read;
    test_write;
    test_tie;
    test_timeout;
    test_reset_abort;
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL missing_acks: %0d completions outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
